// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: shares block-RAM port A between a CPU and an IO/DMA    |
// | requester; optional macro ARB_ROUND_ROBIN_EN selects round-robin.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t     state;
  logic       owner_io;
  logic [2:0] wait_cnt;
  logic       any_req;
  logic       io_wins;

  assign any_req = cpu_req | io_req;

`ifdef ARB_ROUND_ROBIN_EN
  // owner_io doubles as the last-granted flag; resetting it to IO lets the CPU win the first tie.
  assign io_wins = io_req & (~cpu_req | ~owner_io);
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starve;
  assign io_wins = io_req & (~cpu_req | (starve == STARVE_LIM));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner_io   <= 1'b1;
      wait_cnt   <= '0;
      cpu_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      io_gnt     <= 1'b0;
      io_rvalid  <= 1'b0;
      io_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
      starve     <= '0;
`endif
    end else begin
      cpu_gnt    <= 1'b0;
      io_gnt     <= 1'b0;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          mem_wren <= 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
          // Only CPU grants taken over a waiting IO request count toward starvation.
          if (!io_req || io_wins)
            starve <= '0;
          else if (cpu_req && starve != STARVE_LIM)
            starve <= starve + 4'd1;
`endif
          if (any_req) begin
            owner_io <= io_wins;
            state    <= ACCESS;
            if (io_wins) begin
              mem_addr  <= io_addr;
              mem_wdata <= io_wdata;
              mem_wren  <= io_we;
              io_gnt    <= 1'b1;
            end else begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_wren  <= cpu_we;
              cpu_gnt   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          mem_wren <= 1'b0;
          if (mem_wren) begin
            state <= IDLE;
          end else begin
            wait_cnt <= LAT_LOAD;
            state    <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (wait_cnt == 3'd0) begin
            state <= IDLE;
            if (owner_io) begin
              io_rdata  <= mem_q;
              io_rvalid <= 1'b1;
            end else begin
              cpu_rdata  <= mem_q;
              cpu_rvalid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
